// File: rtl/seq_divider_8x4_if.sv
// Handshake and operand/result bundle for the 8-by-4 sequential divider.
interface seq_divider_8x4_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/seq_divider_8x4.sv
// Restoring 8-by-4 unsigned divider: one quotient bit per cycle, MSB first,
// results registered on entry to DONE, divide-by-zero flagged in one cycle.
module seq_divider_8x4 (
  input  logic              clk,
  input  logic              rst,
  seq_divider_8x4_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [7:0] dvd_q, dvd_d;
  logic [3:0] dvs_q, dvs_d;
  logic [3:0] rem_q, rem_d;
  logic [7:0] quotient_q, quotient_d;
  logic [3:0] remainder_q, remainder_d;
  logic       div_zero_q, div_zero_d;
  logic [4:0] step;

  // One restoring step: returns {quotient bit, new 4-bit partial remainder}.
  function automatic logic [4:0] div_step(input logic [3:0] rem,
                                          input logic       bit_in,
                                          input logic [3:0] dvs);
    logic [4:0] sh;
    sh = {rem, bit_in};
    if (sh >= {1'b0, dvs}) begin
      sh = sh - {1'b0, dvs};
      div_step = {1'b1, sh[3:0]};
    end else begin
      div_step = {1'b0, sh[3:0]};
    end
  endfunction

  assign step = div_step(rem_q, dvd_q[7], dvs_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          dvd_d = bus.dividend;
          dvs_d = bus.divisor;
          cnt_d = 3'd0;
          rem_d = 4'd0;
          if (bus.divisor == 4'd0) begin
            state_d     = DONE;
            quotient_d  = 8'hFF;
            remainder_d = 4'd0;
            div_zero_d  = 1'b1;
          end else begin
            state_d = CALC;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        dvd_d = {dvd_q[6:0], step[4]};
        rem_d = step[3:0];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d     = DONE;
          quotient_d  = {dvd_q[6:0], step[4]};
          remainder_d = step[3:0];
          div_zero_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      dvd_q       <= 8'd0;
      dvs_q       <= 4'd0;
      rem_q       <= 4'd0;
      quotient_q  <= 8'd0;
      remainder_q <= 4'd0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign bus.busy      = (state_q == CALC);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: doc/seq_divider_8x4.md
SEQ_DIVIDER_8X4 -- requirements
Module: seq_divider_8x4

Interface
REQ-001 The block SHALL have no parameters; operand widths are fixed at 8-bit dividend and 4-bit divisor, matching the 4x4 multiplier product/operand widths.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a division; sampled on rising clk.
REQ-005 dividend  input  8  unsigned dividend (e.g. a multiplier product P).
REQ-006 divisor  input  4  unsigned divisor.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse marking valid results.
REQ-009 quotient  output  8  unsigned quotient, held until the next completion.
REQ-010 remainder  output  4  unsigned remainder, held until the next completion.
REQ-011 div_zero  output  1  high with results when the captured divisor was 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-013 IDLE or DONE with start=1 at edge E0: capture dividend and divisor, clear the iteration counter, and go to CALC (divisor != 0) or DONE (divisor == 0).
REQ-014 IDLE with start=0: stay in IDLE; DONE with start=0: go to IDLE.
REQ-015 The state machine SHALL ignore start while in CALC and SHALL NOT re-capture operands there.
REQ-016 Operand input changes after E0 SHALL NOT affect the running division.
REQ-017 CALC SHALL perform restoring division, producing one quotient bit per cycle, MSB first.
REQ-018 Each CALC step SHALL shift the 5-bit partial remainder left, bringing in the next dividend bit.
REQ-019 In each step, if partial remainder >= divisor, the block SHALL subtract the divisor and set the quotient bit to 1; otherwise it SHALL set the bit to 0.
REQ-020 CALC SHALL last exactly 8 cycles (edges E1..E8); after E8 the state SHALL be DONE.
REQ-021 The partial remainder SHALL be 5 bits wide so the compare never overflows; the final remainder SHALL be < divisor and fit in 4 bits.
REQ-022 busy SHALL be 1 exactly while in CALC; it rises after E0 and falls after E8.
REQ-023 done SHALL be 1 exactly while in DONE, for one cycle unless a new start is accepted in that same cycle.
REQ-024 Normal-case latency: done high in the cycle after E8, i.e. 9 edges after start was sampled.
REQ-025 Divide-by-zero latency: done high in the cycle after E0.
REQ-026 Registered quotient, remainder and div_zero SHALL update only on entry to DONE, and SHALL hold their values during CALC and IDLE.
REQ-027 Divide by zero SHALL give quotient=8'hFF, remainder=4'h0 and div_zero=1.
REQ-028 Any non-zero division SHALL give div_zero=0.
REQ-029 Results SHALL be exact for all 256x15 non-zero operand pairs: dividend = quotient*divisor + remainder, with remainder < divisor.
REQ-030 When start=1 in DONE, done SHALL be high in that cycle and the new operation SHALL begin at that edge (back-to-back issue, no idle gap).

Reset
REQ-031 With rst=1, the block SHALL go immediately, without waiting for clk, to IDLE with busy=0, done=0, quotient=0, remainder=0, div_zero=0, and the counter and partial remainder cleared.
REQ-032 Reset asserted mid-CALC SHALL abort the division with no done pulse; the results read 0.
REQ-033 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-034 200/7, start pulsed one cycle -> busy for 8 cycles, done one cycle after, quotient=28, remainder=4, div_zero=0.
REQ-035 255/15 -> quotient=17, remainder=0; 5/9 -> quotient=0, remainder=5; 0/1 -> quotient=0, remainder=0.
REQ-036 Divisor 0 with dividend 8'hA5 -> done one cycle after start, quotient=8'hFF, remainder=0, div_zero=1, busy never high.
REQ-037 Start held high for 20 cycles with operands changing every cycle -> first op result only (captured at E0), next op accepted in DONE cycle, back-to-back done pulses 9 cycles apart.
REQ-038 rst asserted asynchronously at cycle 4 of CALC -> all outputs 0 immediately, no done pulse, then 100/3 -> quotient=33, remainder=1.
REQ-039 Exhaustive sweep of all 256x16 operand pairs against a reference model -> zero mismatches, latency 9 for non-zero divisors, 1 for divisor 0.
